res_buffer_reader: RTL

RES_BUFFER_READER -- requirements
Module: res_buffer_reader

---
 rtl/res_buffer_reader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/res_buffer_reader.sv
// res_buffer_reader: streams a block of result words out of a synchronous
// result buffer through a 2-entry prefetch FIFO with a valid/ready output.
// Build option: define RES_BUFFER_READER_RELU_EN to clamp negative
// (two's complement) words to zero as they enter the FIFO.
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | issuing reads and streaming words, busy high
// FINISH | one-cycle done pulse, busy already low
module res_buffer_reader #(
  parameter int BIT_DEPTH  = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [BIT_DEPTH-1:0]  mem_rd_data,
  output logic [BIT_DEPTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   issue_left_q, issue_left_d;
  logic [ADDR_WIDTH:0]   out_left_q, out_left_d;
  logic                  inflight_q;
  logic [BIT_DEPTH-1:0]  fifo_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            fifo_cnt_q;

  logic                  pop, push, rd_en;
  logic [2:0]            occ_after_pop;
  logic [BIT_DEPTH-1:0]  wr_word;

  // A word leaving this cycle frees its slot for a read issued in the same
  // cycle; counting it is what allows one word per cycle with a 2-deep FIFO.
  assign pop           = (fifo_cnt_q != 2'd0) && out_ready;
  assign push          = inflight_q;
  assign occ_after_pop = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en         = (state_q == S_RUN) && (issue_left_q != '0) && (occ_after_pop < 3'd2);

  assign mem_rd_en   = rd_en;
  assign mem_rd_addr = rd_en ? addr_q : '0;
  assign out_valid   = (fifo_cnt_q != 2'd0);
  assign out_data    = fifo_q[rd_ptr_q];
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_FINISH);

`ifdef RES_BUFFER_READER_RELU_EN
  assign wr_word = mem_rd_data[BIT_DEPTH-1] ? '0 : mem_rd_data;
`else
  assign wr_word = mem_rd_data;
`endif

  // Sequencer next state: latch the request, step address and counters.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    out_left_d   = out_left_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_RUN;
          addr_d       = base_addr;
          issue_left_d = count;
          out_left_d   = count;
        end
      end
      S_RUN: begin
        if (rd_en) begin
          addr_d       = addr_q + ADDR_ONE;
          issue_left_d = issue_left_q - CNT_ONE;
        end
        if (pop) begin
          out_left_d = out_left_q - CNT_ONE;
        end
        if ((out_left_q == '0) || (pop && (out_left_q == CNT_ONE))) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, in-flight tracking and prefetch FIFO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      out_left_q   <= '0;
      inflight_q   <= 1'b0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      fifo_cnt_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      out_left_q   <= out_left_d;
      inflight_q   <= rd_en;
      if (push) begin
        fifo_q[wr_ptr_q] <= wr_word;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
